// File: rtl/rr_stream_mux_pkg.sv
// rtl/rr_stream_mux_pkg.sv - shared helpers for the round-robin stream mux
package rr_stream_mux_pkg;

   // Channel index width; a 1-bit index is kept even for degenerate N.
   function automatic int idx_width(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

   function automatic int wrap_inc(input int v, input int n);
      return (v >= n - 1) ? 0 : v + 1;
   endfunction

endpackage

// File: rtl/rr_stream_mux_if.sv
// rtl/rr_stream_mux_if.sv - producer/consumer stream bundle for rr_stream_mux
// Optional force-select ports under RR_STREAM_MUX_FORCE_SEL_EN.
interface rr_stream_mux_if #(
   parameter int N = 4,
   parameter int W = 8
);
   localparam int SW = rr_stream_mux_pkg::idx_width(N);

   logic [N*W-1:0] in_data;
   logic [N-1:0]   in_valid;
   logic [N-1:0]   in_ready;
   logic [W-1:0]   out_data;
   logic [SW-1:0]  out_ch;
   logic           out_valid;
   logic           out_ready;
`ifdef RR_STREAM_MUX_FORCE_SEL_EN
   logic           force_en;
   logic [SW-1:0]  force_sel;
`endif

   modport slave (
      input  in_data, in_valid, out_ready,
`ifdef RR_STREAM_MUX_FORCE_SEL_EN
      input  force_en, force_sel,
`endif
      output in_ready, out_data, out_ch, out_valid
   );

   modport master (
      output in_data, in_valid, out_ready,
`ifdef RR_STREAM_MUX_FORCE_SEL_EN
      output force_en, force_sel,
`endif
      input  in_ready, out_data, out_ch, out_valid
   );

endinterface

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - rotating-priority search starting at ptr, wrapping modulo N
module rr_arbiter
   import rr_stream_mux_pkg::*;
#(
   parameter int N = 4,
   localparam int SW = idx_width(N)
) (
   input  logic [N-1:0]  req,
   input  logic [SW-1:0] ptr,
   input  logic          enable,
   output logic [N-1:0]  grant,
   output logic [SW-1:0] g,
   output logic          any
);

   int j;

   always_comb begin
      grant = '0;
      g     = '0;
      any   = 1'b0;
      j     = 0;
      for (int i = 0; i < N; i++) begin
         j = int'(ptr) + i;
         if (j >= N) j = j - N;
         if (!any && req[j]) begin
            any      = 1'b1;
            g        = j[SW-1:0];
            grant[j] = 1'b1;
         end
      end
      // any reports a pending request; only the grant vector is qualified.
      if (!enable) grant = '0;
   end

endmodule

// File: rtl/rr_stream_mux.sv
// rtl/rr_stream_mux.sv - N-channel round-robin mux with a one-beat registered output
// Optional force-select controlled by RR_STREAM_MUX_FORCE_SEL_EN.
module rr_stream_mux #(
   parameter int N = 4,
   parameter int W = 8
) (
   input logic          clk,
   input logic          rst,
   rr_stream_mux_if.slave bus
);
   import rr_stream_mux_pkg::*;

   localparam int SW = idx_width(N);
   typedef logic [SW-1:0] idx_t;

   idx_t         ptr;
   idx_t         g;
   logic [N-1:0] req;
   logic [N-1:0] grant;
   logic         any;
   logic         load;
   logic         hold_ptr;

   assign load = ~bus.out_valid | bus.out_ready;

`ifdef RR_STREAM_MUX_FORCE_SEL_EN
   // Forcing narrows eligibility to one channel and freezes the rotation.
   always_comb begin
      req      = bus.in_valid;
      hold_ptr = 1'b0;
      if (bus.force_en) begin
         hold_ptr = 1'b1;
         req      = '0;
         if (int'(bus.force_sel) < N)
            req[bus.force_sel] = bus.in_valid[bus.force_sel];
      end
   end
`else
   assign req      = bus.in_valid;
   assign hold_ptr = 1'b0;
`endif

   rr_arbiter #(.N(N)) u_arb (
      .req    (req),
      .ptr    (ptr),
      .enable (load),
      .grant  (grant),
      .g      (g),
      .any    (any)
   );

   assign bus.in_ready = grant;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus.out_data  <= '0;
         bus.out_ch    <= '0;
         bus.out_valid <= 1'b0;
         ptr           <= '0;
      end else if (load) begin
         if (any) begin
            bus.out_data  <= bus.in_data[int'(g)*W +: W];
            bus.out_ch    <= g;
            bus.out_valid <= 1'b1;
            if (!hold_ptr) ptr <= idx_t'(wrap_inc(int'(g), N));
         end else begin
            bus.out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_rr_stream_mux.sv
// tb/tb_rr_stream_mux.sv - scoreboard bench for rr_stream_mux (N=4 main, N=5 wrap case)
module tb_rr_stream_mux;
   localparam int N = 4;
   localparam int W = 8;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   rr_stream_mux_if #(.N(N), .W(W)) bus ();
   rr_stream_mux #(.N(N), .W(W)) dut (.clk(clk), .rst(rst), .bus(bus));

   rr_stream_mux_if #(.N(5), .W(W)) bus5 ();
   rr_stream_mux #(.N(5), .W(W)) dut5 (.clk(clk), .rst(rst), .bus(bus5));

   int vectors = 0;
   int miscompares = 0;

   typedef struct {
      logic [1:0] ch;
      logic [7:0] data;
   } beat_t;

   beat_t sbq[$];
   int    m_ptr = 0;
   bit    m_ov = 1'b0;
   bit    m_fen = 1'b0;
   int    m_fsel = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int model_grant(input logic [N-1:0] v);
      if (m_fen) return (m_fsel < N && v[m_fsel]) ? m_fsel : -1;
      for (int i = 0; i < N; i++) begin
         if (v[(m_ptr + i) % N]) return (m_ptr + i) % N;
      end
      return -1;
   endfunction

   task automatic drive(input logic [N-1:0] v, input logic r);
      bus.in_valid  = v;
      bus.out_ready = r;
      bus.in_data   = $urandom;
   endtask

   // Checks current outputs against the model, then advances model and DUT one cycle.
   task automatic step(input string tag);
      int          gi;
      bit          load;
      logic [N-1:0] exp_rdy;
      beat_t       b;
      #1;
      check($sformatf("%s/out_valid", tag), bus.out_valid, m_ov);
      if (m_ov && sbq.size() > 0) begin
         check($sformatf("%s/out_ch", tag), bus.out_ch, sbq[0].ch);
         check($sformatf("%s/out_data", tag), bus.out_data, sbq[0].data);
      end
      load = !m_ov || bus.out_ready;
      gi = model_grant(bus.in_valid);
      exp_rdy = '0;
      if (load && gi >= 0) exp_rdy[gi] = 1'b1;
      check($sformatf("%s/in_ready", tag), bus.in_ready, exp_rdy);
      if (m_ov && bus.out_ready) void'(sbq.pop_front());
      if (load) begin
         if (gi >= 0) begin
            b.ch   = gi[1:0];
            b.data = bus.in_data[gi*W +: W];
            sbq.push_back(b);
            m_ov = 1'b1;
            if (!m_fen) m_ptr = (gi + 1) % N;
         end else begin
            m_ov = 1'b0;
         end
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      rst = 1'b1;
      bus.in_valid = '0;
      bus.in_data = '0;
      bus.out_ready = 1'b0;
      bus5.in_valid = '0;
      bus5.in_data = '0;
      bus5.out_ready = 1'b1;
`ifdef RR_STREAM_MUX_FORCE_SEL_EN
      bus.force_en = 1'b0;
      bus.force_sel = '0;
      bus5.force_en = 1'b0;
      bus5.force_sel = '0;
`endif
      @(negedge clk);
      @(negedge clk);
      check("reset/out_valid", bus.out_valid, 0);
      check("reset/out_ch", bus.out_ch, 0);
      check("reset/out_data", bus.out_data, 0);
      rst = 1'b0;

      // Single channel request
      drive(4'b0100, 1'b1);
      bus.in_data[23:16] = 8'hA5;
      step("single");
      drive(4'b1111, 1'b1);
      #1;
      check("single/data", bus.out_data, 8'hA5);
      check("single/ch", bus.out_ch, 2);
      check("single/ptr3", bus.in_ready, 4'b1000);
      step("after_single");

      // Fairness: all valid, consumer always ready
      for (int i = 0; i < 9; i++) begin
         drive(4'b1111, 1'b1);
         step("fair");
      end

      // Backpressure: full output held for three cycles, then pop+load
      for (int i = 0; i < 3; i++) begin
         drive(4'b1111, 1'b0);
         step("bp_hold");
      end
      drive(4'b1111, 1'b1);
      step("bp_release");

      // Random valids and backpressure, including valids dropped without grant
      for (int i = 0; i < 30; i++) begin
         drive(4'($urandom), 1'($urandom));
         step("rand");
      end

      // Asynchronous reset with a beat held
      drive(4'b1111, 1'b1);
      step("pre_rst");
      bus.out_ready = 1'b0;
      #3;
      rst = 1'b1;
      #1;
      check("midrst/out_valid", bus.out_valid, 0);
      check("midrst/out_ch", bus.out_ch, 0);
      check("midrst/out_data", bus.out_data, 0);
      sbq.delete();
      m_ov = 1'b0;
      m_ptr = 0;
      @(negedge clk);
      rst = 1'b0;
      drive(4'b1111, 1'b1);
      #1;
      check("postrst/first_grant", bus.in_ready, 4'b0001);
      step("postrst");

`ifdef RR_STREAM_MUX_FORCE_SEL_EN
      bus.force_en = 1'b1;
      bus.force_sel = 2'd3;
      m_fen = 1'b1;
      m_fsel = 3;
      for (int i = 0; i < 4; i++) begin
         drive(4'b1111, 1'b1);
         step("force");
      end
      for (int i = 0; i < 2; i++) begin
         drive(4'b0111, 1'b1);
         step("force_idle");
      end
      bus.force_en = 1'b0;
      m_fen = 1'b0;
      for (int i = 0; i < 4; i++) begin
         drive(4'b1111, 1'b1);
         step("unforce");
      end
`endif

      for (int i = 0; i < 2; i++) begin
         drive(4'b0000, 1'b1);
         step("drain");
      end

      // N=5: reach ptr=4, then skip-and-wrap to channel 1
      bus5.in_data = 40'h44_33_22_11_00;
      bus5.in_valid = 5'b01000;
      #1;
      check("n5/grant3", bus5.in_ready, 5'b01000);
      @(negedge clk);
      bus5.in_valid = 5'b00010;
      #1;
      check("n5/wrap_g1", bus5.in_ready, 5'b00010);
      check("n5/out_ch3", bus5.out_ch, 3);
      check("n5/out_data3", bus5.out_data, 8'h33);
      @(negedge clk);
      bus5.in_valid = 5'b11111;
      #1;
      check("n5/ptr2", bus5.in_ready, 5'b00100);
      check("n5/out_ch1", bus5.out_ch, 1);
      @(negedge clk);
      bus5.in_valid = 5'b10000;
      #1;
      check("n5/grant4", bus5.in_ready, 5'b10000);
      @(negedge clk);
      bus5.in_valid = 5'b11111;
      #1;
      check("n5/ptr_wrap0", bus5.in_ready, 5'b00001);
      check("n5/out_ch4", bus5.out_ch, 4);
      @(negedge clk);
      bus5.in_valid = '0;

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
